idct_transpose_buffer: RTL and testbench
========================================

Name: idct_transpose_buffer

Overview:
Ping-pong 8x8 transpose buffer between the row IDCT stage and the column IDCT stage. It accepts one 8-word row result per handshake. It emits the completed block one column per handshake, in the input permutation the 1-D IDCT stage expects. Double banking lets one block be written while the previous block is read out, giving a sustained throughput of 8 cycles per block.

Parameters:
DATA_W, 32, width of each signed coefficient word
PERMUTE, 1, 1 = emit columns in IDCT input order (0,4,6,2,1,7,5,3); 0 = natural order 0..7

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  row word set on in_d0..in_d7 is valid
in_ready  out  1  buffer can accept a row this cycle
in_d0..in_d7  in  DATA_W each  row elements 0..7, natural order (row IDCT y0..y7)
out_valid  out  1  column on out_c0..out_c7 is valid
out_ready  in  1  consumer takes the column this cycle
out_c0..out_c7  out  DATA_W each  column elements, order set by PERMUTE
out_col  out  3  index (0..7) of the column currently presented
out_last  out  1  high with out_valid when out_col==7

Behaviour:
- State: two banks of 8x8 DATA_W registers; wr_bank, rd_bank (1 bit each); wr_row, rd_col (3 bits each); full[1:0].
- Reset: wr_bank=rd_bank=0, wr_row=rd_col=0, full=00. Outputs after reset: in_ready=1, out_valid=0, out_col=0, out_last=0, out_c*=0. Bank storage is not reset.
- in_ready = !full[wr_bank]. A row is accepted when in_valid && in_ready.
- On accept: bank[wr_bank][wr_row][0..7] <= in_d0..in_d7; wr_row++.
- When the accepted row is row 7: set full[wr_bank], toggle wr_bank, wr_row wraps to 0.
- out_valid = full[rd_bank]. out_col = rd_col. out_last = out_valid && rd_col==7.
- PERMUTE=1: out_c0..out_c7 = bank[rd_bank][r][rd_col] for r = 0,4,6,2,1,7,5,3 respectively.
- PERMUTE=0: out_ck = bank[rd_bank][k][rd_col].
- out_c* are forced to 0 whenever out_valid=0.
- On out_valid && out_ready: rd_col++. When rd_col==7: clear full[rd_bank], toggle rd_bank, rd_col wraps to 0.
- Latency: out_valid rises the cycle after the 8th row of a block is accepted. No combinational path from in_* to out_*. in_ready depends only on registered state.
- Simultaneous events:
  - Setting full on one bank and clearing full on the other in the same cycle both take effect.
  - Set and clear can never target the same bank: writes only go to a non-full bank, reads only come from a full bank.
- Both banks full: in_ready=0. It returns to 1 the cycle after the last column of rd_bank is consumed.
- Both banks empty: out_valid=0, and out_ready is ignored.
- in_valid while in_ready=0: ignored; the producer holds its data.
- Mid-operation reset discards any partial or full blocks. There is no output glitch: out_valid=0 on the first cycle after reset.
- Data is passed through bit-exact, signed, with no arithmetic, rounding or clipping.

Decomposition:
- Shared package idct_pkg holds:
  - DATA_W default
  - N=8 block dimension
  - IDCT_IN_ORDER constant array {0,4,6,2,1,7,5,3}
  - coefficient word typedef (signed DATA_W), which the row/column IDCT stages also use
- One sub-module is natural: idct_tp_bank, a single 8x8 register bank with a row-write port (we, row index, 8 words) and a combinational column-read port (col index, 8 words). It is instantiated twice; the top level holds pointers, counters, full flags and output permutation/gating.

Test Plan:
- Single block, PERMUTE=1, out_ready=1: rows with element (r,c)=8r+c → out_valid one cycle after 8th accept. Column k gives out_c0..c7 = k,32+k,48+k,16+k,8+k,56+k,40+k,24+k. out_last only on k=7. Exactly 8 handshakes.
- Back-pressure: out_ready=0, in_valid=1 continuously → 16 rows accepted, then in_ready=0. The 17th row is held. Raise out_ready → in_ready=1 the cycle after the 8th column handshake, then the 17th row is accepted.
- Streaming: 4 back-to-back blocks, in_valid=out_ready=1 → after the first fill, out_valid stays continuously high, 32 columns in 32 cycles, no bubbles, blocks emitted in order.
- Reset mid-block: accept 5 rows, assert reset 1 cycle, then send a full block of 0xFFFFFFFF (-1) → only -1 words appear, sign preserved, and out_valid was 0 right after reset.
- PERMUTE=0 with the pattern from test 1 → column k gives out_c0..c7 = k,8+k,...,56+k.
- Random in_valid/out_ready (50%), 200 random signed blocks → scoreboard vs transpose+permute model. in_ready never high with both banks full. out_c*=0 whenever out_valid=0.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT datapath: block size, default word width,
// the 1-D IDCT input permutation and the signed coefficient word type used by
// the row stage, the transpose buffer and the column stage.
package idct_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned N              = 8;
    localparam int unsigned IDX_W          = 3;

    typedef logic [IDX_W-1:0] idx_t;

    // Element order presented to the 1-D IDCT butterfly inputs.
    localparam idx_t IDCT_IN_ORDER [N] = '{3'd0, 3'd4, 3'd6, 3'd2, 3'd1, 3'd7, 3'd5, 3'd3};

    typedef logic signed [DATA_W_DEFAULT-1:0] coef_t;

endpackage

// File: rtl/idct_tp_bank.sv
// One 8x8 register bank of the transpose buffer.
//   clk      : clock
//   we_i     : write the row on row_d_i into row row_i
//   row_i    : row index for the write
//   row_d_i  : 8 words, element c goes to column c
//   col_i    : column index for the combinational read
//   col_d_o  : 8 words, element r is bank[r][col_i]
// Storage is not reset; validity is tracked by the owner.
module idct_tp_bank
    import idct_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [IDX_W-1:0]         row_i,
    input  logic signed [DATA_W-1:0] row_d_i [N],
    input  logic [IDX_W-1:0]         col_i,
    output logic signed [DATA_W-1:0] col_d_o [N]
);

    logic signed [DATA_W-1:0] mem_q [N][N];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[row_i] <= row_d_i;
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < N; r++) begin
            col_d_o[r] = mem_q[r][col_i];
        end
    end

endmodule

// File: rtl/idct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between row and column IDCT stages.
// Rows are written into one bank while the other bank is read column-wise.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : row handshake, row on in_d0..in_d7 (natural order)
//   out_valid/out_ready : column handshake, column on out_c0..out_c7
//   out_col             : index of the presented column
//   out_last            : presented column is column 7
// PERMUTE=1 emits column elements in IDCT input order, 0 in natural order.
// out_c* are zero whenever out_valid is low.
module idct_transpose_buffer
    import idct_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned PERMUTE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_d0,
    input  logic signed [DATA_W-1:0] in_d1,
    input  logic signed [DATA_W-1:0] in_d2,
    input  logic signed [DATA_W-1:0] in_d3,
    input  logic signed [DATA_W-1:0] in_d4,
    input  logic signed [DATA_W-1:0] in_d5,
    input  logic signed [DATA_W-1:0] in_d6,
    input  logic signed [DATA_W-1:0] in_d7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_c0,
    output logic signed [DATA_W-1:0] out_c1,
    output logic signed [DATA_W-1:0] out_c2,
    output logic signed [DATA_W-1:0] out_c3,
    output logic signed [DATA_W-1:0] out_c4,
    output logic signed [DATA_W-1:0] out_c5,
    output logic signed [DATA_W-1:0] out_c6,
    output logic signed [DATA_W-1:0] out_c7,
    output logic [2:0]               out_col,
    output logic                     out_last
);

    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_row_q, wr_row_d;
    logic [IDX_W-1:0] rd_col_q, rd_col_d;
    logic [1:0]       full_q, full_d;

    logic accept;
    logic take;

    logic signed [DATA_W-1:0] row_d  [N];
    logic signed [DATA_W-1:0] rd0    [N];
    logic signed [DATA_W-1:0] rd1    [N];
    logic signed [DATA_W-1:0] out_w  [N];

    assign row_d[0] = in_d0;
    assign row_d[1] = in_d1;
    assign row_d[2] = in_d2;
    assign row_d[3] = in_d3;
    assign row_d[4] = in_d4;
    assign row_d[5] = in_d5;
    assign row_d[6] = in_d6;
    assign row_d[7] = in_d7;

    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign out_col   = rd_col_q;
    assign out_last  = out_valid && (rd_col_q == 3'd7);

    idct_tp_bank #(.DATA_W(DATA_W)) u_bank0 (
        .clk     (clk),
        .we_i    (accept && !wr_bank_q),
        .row_i   (wr_row_q),
        .row_d_i (row_d),
        .col_i   (rd_col_q),
        .col_d_o (rd0)
    );

    idct_tp_bank #(.DATA_W(DATA_W)) u_bank1 (
        .clk     (clk),
        .we_i    (accept && wr_bank_q),
        .row_i   (wr_row_q),
        .row_d_i (row_d),
        .col_i   (rd_col_q),
        .col_d_o (rd1)
    );

    // Set and clear never hit the same bank: writes target a non-full bank,
    // reads a full one, so both updates can be applied independently.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_col_d  = rd_col_q;
        full_d    = full_q;
        if (accept) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        if (take) begin
            rd_col_d = rd_col_q + 3'd1;
            if (rd_col_q == 3'd7) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            logic [IDX_W-1:0] src;
            src = (PERMUTE != 0) ? IDCT_IN_ORDER[k] : IDX_W'(k);
            if (!out_valid) begin
                out_w[k] = '0;
            end else if (rd_bank_q) begin
                out_w[k] = rd1[src];
            end else begin
                out_w[k] = rd0[src];
            end
        end
    end

    assign out_c0 = out_w[0];
    assign out_c1 = out_w[1];
    assign out_c2 = out_w[2];
    assign out_c3 = out_w[3];
    assign out_c4 = out_w[4];
    assign out_c5 = out_w[5];
    assign out_c6 = out_w[6];
    assign out_c7 = out_w[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_col_q  <= '0;
            full_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_col_q  <= rd_col_d;
            full_q    <= full_d;
        end
    end

endmodule

// File: tb/tb_idct_transpose_buffer.sv
// Directed and random checks of idct_transpose_buffer. Two instances share
// the stimulus: dut uses PERMUTE=1, dut_nat uses PERMUTE=0.
module tb_idct_transpose_buffer;

    localparam int unsigned DW = 32;
    typedef logic signed [DW-1:0] w_t;
    typedef w_t row_t [8];

    typedef struct {
        w_t perm [8];
        w_t nat  [8];
    } colx_t;

    typedef struct {
        int unsigned col;
        w_t          perm [8];
        w_t          nat  [8];
        logic        last;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    w_t   din [8];

    logic       in_ready, out_valid, out_last;
    logic [2:0] out_col;
    w_t         oc [8];

    logic       in_ready_n, out_valid_n, out_last_n;
    logic [2:0] out_col_n;
    w_t         ocn [8];

    int errors = 0;
    int checks = 0;

    int    order [8] = '{0, 4, 6, 2, 1, 7, 5, 3};
    int    mfull, rows_in, mcol;
    w_t    blk [8][8];
    colx_t expq [$];
    bit    last_acc, last_tk;

    always #5 clk = ~clk;

    idct_transpose_buffer #(.DATA_W(DW), .PERMUTE(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_d0(din[0]), .in_d1(din[1]), .in_d2(din[2]), .in_d3(din[3]),
        .in_d4(din[4]), .in_d5(din[5]), .in_d6(din[6]), .in_d7(din[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c0(oc[0]), .out_c1(oc[1]), .out_c2(oc[2]), .out_c3(oc[3]),
        .out_c4(oc[4]), .out_c5(oc[5]), .out_c6(oc[6]), .out_c7(oc[7]),
        .out_col(out_col), .out_last(out_last)
    );

    idct_transpose_buffer #(.DATA_W(DW), .PERMUTE(0)) dut_nat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_n),
        .in_d0(din[0]), .in_d1(din[1]), .in_d2(din[2]), .in_d3(din[3]),
        .in_d4(din[4]), .in_d5(din[5]), .in_d6(din[6]), .in_d7(din[7]),
        .out_valid(out_valid_n), .out_ready(out_ready),
        .out_c0(ocn[0]), .out_c1(ocn[1]), .out_c2(ocn[2]), .out_c3(ocn[3]),
        .out_c4(ocn[4]), .out_c5(ocn[5]), .out_c6(ocn[6]), .out_c7(ocn[7]),
        .out_col(out_col_n), .out_last(out_last_n)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic row_t mkrow(input int base);
        row_t r;
        for (int c = 0; c < 8; c++) r[c] = base + c;
        return r;
    endfunction

    task automatic model_clear();
        mfull = 0;
        rows_in = 0;
        mcol = 0;
        expq.delete();
    endtask

    // One clock: check outputs against the scoreboard, clock, update model.
    task automatic step();
        bit    acc, tk, rst_s, done;
        colx_t e;
        #1;
        chk("in_ready", in_ready, mfull < 2);
        chk("out_valid", out_valid, mfull > 0);
        chk("out_valid_nat", out_valid_n, mfull > 0);
        chk("out_col", out_col, mcol);
        chk("out_last", out_last, (mfull > 0) && (mcol == 7));
        if (mfull > 0 && expq.size() > 0) begin
            e = expq[0];
        end else begin
            for (int k = 0; k < 8; k++) begin
                e.perm[k] = '0;
                e.nat[k]  = '0;
            end
        end
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("perm_c%0d", k), oc[k], e.perm[k]);
            chk($sformatf("nat_c%0d", k), ocn[k], e.nat[k]);
        end
        rst_s = reset;
        acc   = !reset && in_valid && (mfull < 2);
        tk    = !reset && out_ready && (mfull > 0);
        done  = 0;
        @(posedge clk);
        last_acc = acc;
        last_tk  = tk;
        if (rst_s) begin
            model_clear();
        end else begin
            if (acc) begin
                blk[rows_in] = din;
                rows_in++;
                if (rows_in == 8) begin
                    for (int col = 0; col < 8; col++) begin
                        for (int k = 0; k < 8; k++) begin
                            e.perm[k] = blk[order[k]][col];
                            e.nat[k]  = blk[k][col];
                        end
                        expq.push_back(e);
                    end
                    rows_in = 0;
                    done = 1;
                end
            end
            if (tk) begin
                void'(expq.pop_front());
                mcol = (mcol + 1) % 8;
                if (mcol == 0) mfull--;
            end
            if (done) mfull++;
        end
        #1;
    endtask

    task automatic send_row(input row_t r);
        int n = 0;
        din = r;
        in_valid = 1'b1;
        do begin
            step();
            n++;
        end while (!last_acc && n < 200);
        chk("send_accepted", last_acc, 1);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((mfull > 0 || out_valid) && n < 400) begin
            step();
            n++;
        end
        chk({nm, "_drain_in_time"}, n < 400, 1);
    endtask

    initial begin
        vec_t vt [8];
        row_t cur;
        int   sent, cyc;

        for (int k = 0; k < 8; k++) begin
            vt[k].col  = k;
            vt[k].perm = '{k, 32 + k, 48 + k, 16 + k, 8 + k, 56 + k, 40 + k, 24 + k};
            for (int r = 0; r < 8; r++) vt[k].nat[r] = 8 * r + k;
            vt[k].last = (k == 7);
        end
        din = mkrow(0);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_last", out_last, 0);
        for (int k = 0; k < 8; k++) chk($sformatf("rst_c%0d", k), oc[k], 0);

        // Single block, pattern 8r+c, table-driven column checks
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            send_row(mkrow(8 * r));
            if (r == 6) chk("t1_valid_before_8th", out_valid, 0);
        end
        in_valid = 1'b0;
        chk("t1_valid_after_8th", out_valid, 1);
        for (int v = 0; v < 8; v++) begin
            chk("t1_col", out_col, vt[v].col);
            chk("t1_last", out_last, vt[v].last);
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("t1_perm_col%0d_c%0d", v, k), oc[k], vt[v].perm[k]);
                chk($sformatf("t1_nat_col%0d_c%0d", v, k), ocn[k], vt[v].nat[k]);
            end
            step();
        end
        chk("t1_done_valid", out_valid, 0);

        // Back-pressure: fill both banks, hold the 17th row
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_row(mkrow(1000 + 16 * i));
        chk("t2_ready_both_full", in_ready, 0);
        din = mkrow(1000 + 16 * 16);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_ready_held", in_ready, 0);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            if (j == 6) chk("t2_ready_before_last_col", in_ready, 0);
        end
        chk("t2_ready_after_last_col", in_ready, 1);
        step();
        chk("t2_row17_accepted", last_acc, 1);
        for (int i = 17; i < 24; i++) send_row(mkrow(1000 + 16 * i));
        drain("t2");

        // Streaming 4 blocks back-to-back
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send_row(mkrow(5000 + 64 * (i / 8) + 8 * (i % 8)));
            if (i >= 7) chk("t3_stream_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk("t3_tail_valid", out_valid, 1);
            step();
        end
        chk("t3_end_valid", out_valid, 0);

        // Reset mid-block, then an all -1 block
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_row(mkrow(9000 + 8 * i));
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("t4_valid_after_rst", out_valid, 0);
        chk("t4_ready_after_rst", in_ready, 1);
        chk("t4_col_after_rst", out_col, 0);
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) cur[c] = -1;
            send_row(cur);
        end
        in_valid = 1'b0;
        for (int v = 0; v < 8; v++) begin
            chk("t4_valid", out_valid, 1);
            for (int k = 0; k < 8; k++) chk($sformatf("t4_neg1_c%0d", k), oc[k], 64'hFFFF_FFFF_FFFF_FFFF);
            step();
        end
        chk("t4_end_valid", out_valid, 0);

        // Random handshakes, 200 random blocks against the scoreboard
        sent = 0;
        cyc = 0;
        for (int c = 0; c < 8; c++) cur[c] = $urandom;
        while ((sent < 1600 || mfull > 0) && cyc < 20000) begin
            din = cur;
            in_valid  = (sent < 1600) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            step();
            cyc++;
            if (last_acc) begin
                sent++;
                for (int c = 0; c < 8; c++) cur[c] = $urandom;
            end
        end
        chk("t6_finished_in_time", cyc < 20000, 1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
